pll_lock_supervisor: RTL and testbench

Supervises the system PLL from the board reference clock. It drives the PLL's active-high reset, qualifies its `locked` output, and holds the core in reset until lock has been stable for a programmed time. If lock is lost, or lock does not arrive within a timeout, it re-resets the PLL automatically. It sits between the PLL wrapper and the core reset tree, and runs only on `refclk` because PLL outputs are untrusted until qualified.

---
 rtl/pll_sup_pkg.sv | 32 +++
 rtl/sync_bit.sv | 28 ++
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM states
//   DEF_*           : default parameter values for pll_lock_supervisor
//   timer_width()   : width of the shared state timer for a given parameter set
package pll_sup_pkg;

   typedef enum logic [1:0] {
      PLLRST = 2'd0,
      WAIT   = 2'd1,
      STABLE = 2'd2,
      RUN    = 2'd3
   } pll_sup_state_t;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_CNT_W         = 8;

   // The timer must be able to hold the largest load value; the reset load of RST_CYCLES is
   // one larger than the in-flight reload, so size for max + 1.
   function automatic int unsigned timer_width(input int unsigned rst_cycles,
                                               input int unsigned lock_timeout,
                                               input int unsigned stable_cycles);
      int unsigned m;
      m = rst_cycles;
      if (lock_timeout > m) m = lock_timeout;
      if (stable_cycles > m) m = stable_cycles;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear, both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges of latency
module sync_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: resets the system PLL, qualifies its lock output and holds the core in
// reset until lock has been stable long enough. Re-resets the PLL on lock timeout or loss.
// Runs only on refclk since PLL outputs are untrusted until qualified.
//   refclk        : reference clock, the only clock of this block
//   rst_n         : asynchronous active-low reset
//   locked        : PLL lock indication, asynchronous to refclk
//   force_reset   : synchronous request for a full PLL and core reset cycle
//   pll_rst       : active-high PLL reset
//   core_reset    : active-high core reset, high whenever not in RUN
//   ready         : inverse of core_reset
//   timeout_pulse : one-cycle pulse when WAIT times out
//   lost_pulse    : one-cycle pulse when lock drops in RUN
//   retry_count   : saturating count of WAIT timeouts
//   lost_count    : saturating count of lock losses in RUN
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             locked,
   input  logic             force_reset,
   output logic             pll_rst,
   output logic             core_reset,
   output logic             ready,
   output logic             timeout_pulse,
   output logic             lost_pulse,
   output logic [CNT_W-1:0] retry_count,
   output logic [CNT_W-1:0] lost_count
);

   localparam int unsigned TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   // A state lasting N cycles is entered with N-1 and left on the edge that sees zero. Out of
   // reset the timer holds RST_CYCLES because the reset interval itself is not a PLLRST cycle.
   localparam logic [TW-1:0] RST_INIT = TW'(RST_CYCLES);
   localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STB_LOAD = TW'(STABLE_CYCLES - 1);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   pll_sup_state_t   state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic [CNT_W-1:0] lost_q, lost_d;
   logic             pll_rst_q, core_reset_q, ready_q, timeout_q, lost_pulse_q;

   logic locked_s;
   logic timer_zero;
   logic timeout_evt;
   logic lost_evt;

   sync_bit u_sync_locked (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign timer_zero = (timer_q == '0);

   // Next-state and shared timer.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      timeout_evt = 1'b0;
      lost_evt    = 1'b0;

      unique case (state_q)
         PLLRST: begin
            if (timer_zero) state_d = WAIT;
            else            timer_d = timer_q - TW'(1);
         end
         WAIT: begin
            if (locked_s) begin
               state_d = STABLE;
            end else if (timer_zero) begin
               state_d     = PLLRST;
               timeout_evt = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         STABLE: begin
            // Any drop restarts qualification from WAIT with a fresh timeout.
            if (!locked_s)       state_d = WAIT;
            else if (timer_zero) state_d = RUN;
            else                 timer_d = timer_q - TW'(1);
         end
         RUN: begin
            if (!locked_s) begin
               state_d  = PLLRST;
               lost_evt = 1'b1;
            end
         end
      endcase

      // Forced reset wins over timeout and loss, and suppresses their pulses and counts.
      if (force_reset) begin
         state_d     = PLLRST;
         timeout_evt = 1'b0;
         lost_evt    = 1'b0;
      end

      // Reload on every state entry; a held force_reset keeps re-entering PLLRST.
      if (force_reset || (state_d != state_q)) begin
         unique case (state_d)
            PLLRST: timer_d = RST_LOAD;
            WAIT:   timer_d = TMO_LOAD;
            STABLE: timer_d = STB_LOAD;
            RUN:    timer_d = '0;
         endcase
      end
   end

   // Saturating event counters.
   always_comb begin
      retry_d = retry_q;
      lost_d  = lost_q;
      if (timeout_evt && (retry_q != CNT_MAX)) retry_d = retry_q + CNT_ONE;
      if (lost_evt && (lost_q != CNT_MAX))     lost_d  = lost_q + CNT_ONE;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PLLRST;
         timer_q <= RST_INIT;
         retry_q <= '0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         lost_q  <= lost_d;
      end
   end

   // Outputs are registered from the next state so they switch with the state register.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         pll_rst_q    <= 1'b1;
         core_reset_q <= 1'b1;
         ready_q      <= 1'b0;
         timeout_q    <= 1'b0;
         lost_pulse_q <= 1'b0;
      end else begin
         pll_rst_q    <= (state_d == PLLRST);
         core_reset_q <= (state_d != RUN);
         ready_q      <= (state_d == RUN);
         timeout_q    <= timeout_evt;
         lost_pulse_q <= lost_evt;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign core_reset    = core_reset_q;
   assign ready         = ready_q;
   assign timeout_pulse = timeout_q;
   assign lost_pulse    = lost_pulse_q;
   assign retry_count   = retry_q;
   assign lost_count    = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with small parameters. A behavioural model, written in terms of
// cycles spent in each state, pushes the expected outputs for every edge into a queue; the entry
// is popped and compared just after the edge. Directed checks pin the key timing points.
module tb_pll_lock_supervisor;

   localparam int unsigned RST = 4;
   localparam int unsigned TMO = 20;
   localparam int unsigned STB = 8;
   localparam int unsigned CW  = 3;
   localparam int          SAT = (1 << CW) - 1;

   localparam int M_RST  = 0;
   localparam int M_WAIT = 1;
   localparam int M_STB  = 2;
   localparam int M_RUN  = 3;

   logic          refclk = 1'b0;
   logic          rst_n = 1'b1;
   logic          locked = 1'b0;
   logic          force_reset = 1'b0;
   logic          pll_rst, core_reset, ready, timeout_pulse, lost_pulse;
   logic [CW-1:0] retry_count, lost_count;

   pll_lock_supervisor #(
      .RST_CYCLES    (RST),
      .LOCK_TIMEOUT  (TMO),
      .STABLE_CYCLES (STB),
      .CNT_W         (CW)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .locked        (locked),
      .force_reset   (force_reset),
      .pll_rst       (pll_rst),
      .core_reset    (core_reset),
      .ready         (ready),
      .timeout_pulse (timeout_pulse),
      .lost_pulse    (lost_pulse),
      .retry_count   (retry_count),
      .lost_count    (lost_count)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic pll_rst;
      logic core_reset;
      logic ready;
      logic tp;
      logic lp;
      int   rc;
      int   lc;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;
   int cyc   = -1;

   // Model state.
   int   m_st, m_age, m_rc, m_lc;
   bit   m_first;
   logic m_s1, m_s2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st    = M_RST;
      m_age   = 0;
      m_first = 1'b1;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_rc    = 0;
      m_lc    = 0;
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_step(output exp_t e);
      int nxt;
      int lim;
      bit tp, lp;
      nxt = m_st;
      tp  = 1'b0;
      lp  = 1'b0;
      case (m_st)
         M_RST: begin
            lim = m_first ? RST + 1 : RST;
            if (m_age + 1 >= lim) nxt = M_WAIT;
         end
         M_WAIT: begin
            if (m_s2) nxt = M_STB;
            else if (m_age + 1 >= TMO) begin nxt = M_RST; tp = 1'b1; end
         end
         M_STB: begin
            if (!m_s2) nxt = M_WAIT;
            else if (m_age + 1 >= STB) nxt = M_RUN;
         end
         default: begin
            if (!m_s2) begin nxt = M_RST; lp = 1'b1; end
         end
      endcase
      if (force_reset) begin
         nxt = M_RST;
         tp  = 1'b0;
         lp  = 1'b0;
      end
      if (tp && m_rc < SAT) m_rc++;
      if (lp && m_lc < SAT) m_lc++;
      if (force_reset || nxt != m_st) begin
         m_age   = 0;
         m_first = 1'b0;
      end else begin
         m_age++;
      end
      m_s2 = m_s1;
      m_s1 = locked;
      m_st = nxt;
      e.pll_rst    = (nxt == M_RST);
      e.core_reset = (nxt != M_RUN);
      e.ready      = (nxt == M_RUN);
      e.tp         = tp;
      e.lp         = lp;
      e.rc         = m_rc;
      e.lc         = m_lc;
   endtask

   task automatic tick();
      exp_t e;
      model_step(e);
      sb.push_back(e);
      @(posedge refclk);
      #1;
      cyc++;
      e = sb.pop_front();
      check_val($sformatf("pll_rst@%0d", cyc), pll_rst, e.pll_rst);
      check_val($sformatf("core_reset@%0d", cyc), core_reset, e.core_reset);
      check_val($sformatf("ready@%0d", cyc), ready, e.ready);
      check_val($sformatf("timeout_pulse@%0d", cyc), timeout_pulse, e.tp);
      check_val($sformatf("lost_pulse@%0d", cyc), lost_pulse, e.lp);
      check_val($sformatf("retry_count@%0d", cyc), retry_count, e.rc);
      check_val($sformatf("lost_count@%0d", cyc), lost_count, e.lc);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_pll_rst"}, pll_rst, 1);
      check_val({tag, "_core_reset"}, core_reset, 1);
      check_val({tag, "_ready"}, ready, 0);
      check_val({tag, "_tp"}, timeout_pulse, 0);
      check_val({tag, "_lp"}, lost_pulse, 0);
      check_val({tag, "_retry"}, retry_count, 0);
      check_val({tag, "_lost"}, lost_count, 0);
   endtask

   // Called between edges: asserts reset, checks the immediate effect, then releases it.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      model_reset();
      sb.delete();
      @(posedge refclk);
      #1;
      check_reset_vals("rst_held");
      #2;
      rst_n = 1'b1;
      cyc   = -1;
   endtask

   initial begin
      int fall_at, last_pr, ready_at, rise_n, back, pr27, pr28, tmo_at;
      logic lp_seen;
      int tps[$];

      #1;
      // Clean start.
      locked = 1'b1;
      do_reset();
      fall_at = -1;
      last_pr = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pll_rst) last_pr = cyc;
         if (!core_reset && fall_at < 0) fall_at = cyc;
      end
      check_val("clean_fall_cycle", fall_at, 13);
      check_val("clean_pllrst_last", last_pr, 3);
      check_val("clean_ready", ready, 1);
      check_val("clean_retry", retry_count, 0);
      check_val("clean_lost", lost_count, 0);

      // No lock: timeouts at 24 and 48, then saturation.
      locked = 1'b0;
      do_reset();
      pr27 = -1;
      pr28 = -1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (timeout_pulse) tps.push_back(cyc);
         if (cyc == 27) pr27 = pll_rst;
         if (cyc == 28) pr28 = pll_rst;
      end
      check_val("nolock_tp_count", tps.size(), 2);
      for (int k = 0; k < 2; k++)
         check_val($sformatf("nolock_tp_cycle%0d", k), (k < tps.size()) ? tps[k] : -1, 24 * (k + 1));
      check_val("nolock_pllrst27", pr27, 1);
      check_val("nolock_pllrst28", pr28, 0);
      check_val("nolock_retry2", retry_count, 2);
      for (int i = 0; i < 250; i++) tick();
      check_val("nolock_retry_sat", retry_count, SAT);

      // Unstable lock: short lock returns to WAIT without a retry, then a real lock.
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      locked = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      locked = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check_val("unstable_ready_low", ready, 0);
      check_val("unstable_retry", retry_count, 0);
      locked = 1'b1;
      ready_at = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready && ready_at < 0) ready_at = cyc;
      end
      check_val("unstable_run_cycle", ready_at, 26);
      check_val("unstable_retry_end", retry_count, 0);

      // Loss in RUN: 3-cycle drop.
      locked  = 1'b0;
      rise_n  = -1;
      lp_seen = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         tick();
         if (core_reset && rise_n < 0) begin
            rise_n  = n;
            lp_seen = lost_pulse;
         end
      end
      locked = 1'b1;
      check_val("loss_reaction_edges", rise_n, 3);
      check_val("loss_pulse_coincident", lp_seen, 1);
      back = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ready && back < 0) back = i;
      end
      check_val("loss_rerun_edges", back, 13);
      check_val("loss_count", lost_count, 1);

      // Async reset in RUN with a nonzero lost_count: everything clears before the next edge.
      check_val("pre_async_ready", ready, 1);
      do_reset();
      for (int i = 0; i < 15; i++) tick();
      check_val("post_async_ready", ready, 1);

      // Priority: force_reset on the timeout edge.
      locked = 1'b0;
      do_reset();
      for (int i = 0; i < 24; i++) tick();
      force_reset = 1'b1;
      tick();
      check_val("prio_no_tp", timeout_pulse, 0);
      check_val("prio_retry", retry_count, 0);
      check_val("prio_pllrst", pll_rst, 1);
      for (int i = 0; i < 3; i++) tick();
      check_val("prio_held_pllrst", pll_rst, 1);
      force_reset = 1'b0;
      tmo_at = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (timeout_pulse && tmo_at < 0) tmo_at = cyc;
      end
      check_val("prio_next_timeout", tmo_at, 51);
      check_val("prio_retry_after", retry_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
